mfp_bot_updt_handshake: RTL and testbench

//  Interrupt-style handshake between the Rojobot update strobe and the GPIO slave.
//  - Synchronises the raw BotUpdt strobe and detects its rising edge.
//  - Raises a sticky IO_BotUpdt_Sync flag and snapshots BotInfo so software reads a coherent value.
//  - Clears the flag on a software IO_INT_ACK rising edge; counts updates lost while still pending.
//  - Upstream of the GPIO slave: drives its IO_BotUpdt_Sync/IO_BotInfo, consumes its IO_INT_ACK.

---
 rtl/mfp_bot_updt_handshake_pkg.sv | 11 +
 rtl/mfp_bot_updt_handshake_if.sv | 21 ++
 rtl/mfp_bot_updt_handshake_sync_edge.sv | 34 +++
 rtl/mfp_bot_updt_handshake.sv | 132 +++++++++++++
 tb/tb_mfp_bot_updt_handshake.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/mfp_bot_updt_handshake_pkg.sv
// Shared constants for the Rojobot update handshake.
// State encodings and default overrun counter width.
package mfp_bot_updt_handshake_pkg;

  localparam logic [1:0] BUH_IDLE    = 2'b00;
  localparam logic [1:0] BUH_PENDING = 2'b01;
  localparam logic [1:0] BUH_ACKED   = 2'b10;

  localparam int BUH_OVR_W = 8;

endpackage

// File: rtl/mfp_bot_updt_handshake_if.sv
// GPIO-side handshake bundle: pending flag and snapshot out,
// software acknowledge back.
interface mfp_bot_updt_handshake_if;

  logic        IO_BotUpdt_Sync;
  logic [31:0] IO_BotInfo;
  logic        IO_INT_ACK;

  modport master (
    output IO_BotUpdt_Sync,
    output IO_BotInfo,
    input  IO_INT_ACK
  );

  modport slave (
    input  IO_BotUpdt_Sync,
    input  IO_BotInfo,
    output IO_INT_ACK
  );

endinterface

// File: rtl/mfp_bot_updt_handshake_sync_edge.sv
// Multi-flop synchroniser with rising-edge detect.
// A level already high out of reset is not reported as an edge.
module mfp_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic HCLK,
  input  logic HRESETn,
  input  logic d,
  output logic q,
  output logic rise
);

  logic [STAGES-1:0] chain;
  logic [STAGES-1:0] fill;
  logic              prev;

  // shift the raw level in; fill marks stages holding real samples,
  // and prev is held high until the last stage is real
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      chain <= '0;
      fill  <= '0;
      prev  <= 1'b1;
    end else begin
      chain <= {chain[STAGES-2:0], d};
      fill  <= {fill[STAGES-2:0], 1'b1};
      prev  <= fill[STAGES-1] ? chain[STAGES-1] : 1'b1;
    end
  end

  assign q    = chain[STAGES-1];
  assign rise = q & ~prev;

endmodule

// File: rtl/mfp_bot_updt_handshake.sv
// Rojobot update interrupt handshake toward the GPIO slave:
// sticky pending flag, coherent snapshot, ack edge clear, overrun count.
module mfp_bot_updt_handshake
  import mfp_bot_updt_handshake_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int OVR_W       = BUH_OVR_W,
  parameter int SNAPSHOT    = 1
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  BotUpdt_in,
  input  logic [31:0]           BotInfo_in,
  mfp_bot_updt_handshake_if.master gpio,
  output logic [OVR_W-1:0]      ovr_count,
  output logic                  busy
);

  logic [1:0] state;
  logic [1:0] state_n;
  logic       defer;
  logic       defer_n;
  logic       ack_prev;
  logic       ack_rise;
  logic       upd_lvl;
  logic       upd_pulse;
  logic       snap_ld;
  logic       ovr_inc;
  logic       sync_q;

  mfp_sync_edge #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .d       (BotUpdt_in),
    .q       (upd_lvl),
    .rise    (upd_pulse)
  );

  assign ack_rise = gpio.IO_INT_ACK & ~ack_prev;

  // next state, defer flag and snapshot/counter enables
  always_comb begin
    state_n = state;
    defer_n = defer;
    snap_ld = 1'b0;
    ovr_inc = 1'b0;
    case (state)
      BUH_IDLE: begin
        if (upd_pulse) begin
          state_n = BUH_PENDING;
          snap_ld = 1'b1;
        end
      end
      BUH_PENDING: begin
        if (ack_rise) begin
          state_n = BUH_ACKED;
          if (upd_pulse) begin
            snap_ld = 1'b1;
            defer_n = 1'b1;
          end
        end else if (upd_pulse) begin
          snap_ld = 1'b1;
          ovr_inc = 1'b1;
        end
      end
      BUH_ACKED: begin
        if (upd_pulse) begin
          snap_ld = 1'b1;
          defer_n = 1'b1;
          ovr_inc = defer;
        end
        if (!gpio.IO_INT_ACK) begin
          state_n = (defer || upd_pulse) ? BUH_PENDING : BUH_IDLE;
          defer_n = 1'b0;
        end
      end
      default: begin
        state_n = BUH_IDLE;
        defer_n = 1'b0;
      end
    endcase
  end

  // state, ack history, defer flag and registered pending flag
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state    <= BUH_IDLE;
      defer    <= 1'b0;
      ack_prev <= 1'b0;
      sync_q   <= 1'b0;
    end else begin
      state    <= state_n;
      defer    <= defer_n;
      ack_prev <= gpio.IO_INT_ACK;
      sync_q   <= (state_n == BUH_PENDING);
    end
  end

  // saturating overrun counter, cleared only by reset
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ovr_count <= '0;
    end else if (ovr_inc && (ovr_count != '1)) begin
      ovr_count <= ovr_count + 1'b1;
    end
  end

  generate
    if (SNAPSHOT != 0) begin : g_snap
      logic [31:0] snap;

      // latest BotInfo captured with each accepted update
      always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
          snap <= '0;
        end else if (snap_ld) begin
          snap <= BotInfo_in;
        end
      end

      assign gpio.IO_BotInfo = snap;
    end else begin : g_pass
      assign gpio.IO_BotInfo = BotInfo_in;
    end
  endgenerate

  assign gpio.IO_BotUpdt_Sync = sync_q;
  assign busy                 = (state != BUH_IDLE);

endmodule

// File: tb/tb_mfp_bot_updt_handshake.sv
// Directed bench for the Rojobot update handshake.
// Inputs change 1ns after a rising edge; outputs are checked there too.
module tb_mfp_bot_updt_handshake;

  logic        HCLK;
  logic        HRESETn;
  logic        BotUpdt_in;
  logic [31:0] BotInfo_in;
  logic [7:0]  ovr_count;
  logic        busy;

  int n_chk;
  int n_err;

  mfp_bot_updt_handshake_if gpio();

  mfp_bot_updt_handshake dut (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .BotUpdt_in (BotUpdt_in),
    .BotInfo_in (BotInfo_in),
    .gpio       (gpio),
    .ovr_count  (ovr_count),
    .busy       (busy)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge HCLK);
    #1;
  endtask

  task automatic upd(input logic [31:0] info);
    BotInfo_in = info;
    BotUpdt_in = 1'b1;
    tick(3);
    BotUpdt_in = 1'b0;
    tick(3);
  endtask

  task automatic ack(input logic v);
    gpio.IO_INT_ACK = v;
    tick(1);
  endtask

  task automatic do_reset();
    BotUpdt_in = 1'b0;
    HRESETn    = 1'b0;
    tick(2);
    HRESETn    = 1'b1;
    tick(5);
  endtask

  task automatic single(input string tg, input logic [31:0] info);
    BotInfo_in = info;
    BotUpdt_in = 1'b1;
    tick(2);
    chk({tg, "_lat_sync"}, gpio.IO_BotUpdt_Sync, 1'b0);
    tick(1);
    chk({tg, "_sync"}, gpio.IO_BotUpdt_Sync, 1'b1);
    chk({tg, "_info"}, gpio.IO_BotInfo, info);
    chk({tg, "_busy"}, busy, 1'b1);
    BotUpdt_in = 1'b0;
    tick(3);
    ack(1'b1);
    chk({tg, "_ack_sync"}, gpio.IO_BotUpdt_Sync, 1'b0);
    chk({tg, "_ack_busy"}, busy, 1'b1);
    ack(1'b0);
    chk({tg, "_idle_busy"}, busy, 1'b0);
    chk({tg, "_idle_sync"}, gpio.IO_BotUpdt_Sync, 1'b0);
    chk({tg, "_ovr"}, ovr_count, 8'h00);
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    HRESETn         = 1'b0;
    BotUpdt_in      = 1'b1;
    BotInfo_in      = 32'hDEAD_BEEF;
    gpio.IO_INT_ACK = 1'b1;

    // reset with strobe and ack held high
    tick(3);
    chk("rst_sync", gpio.IO_BotUpdt_Sync, 1'b0);
    chk("rst_info", gpio.IO_BotInfo, 32'h0);
    chk("rst_ovr", ovr_count, 8'h00);
    chk("rst_busy", busy, 1'b0);
    HRESETn = 1'b1;
    tick(6);
    chk("rel_sync", gpio.IO_BotUpdt_Sync, 1'b0);
    chk("rel_busy", busy, 1'b0);
    gpio.IO_INT_ACK = 1'b0;
    BotUpdt_in      = 1'b0;
    tick(3);
    chk("rel_low_busy", busy, 1'b0);

    // single update
    single("t2", 32'h1234_5678);

    // collision of update and ack rise in PENDING
    upd(32'h0000_000C);
    chk("t4_pend_sync", gpio.IO_BotUpdt_Sync, 1'b1);
    BotInfo_in = 32'h0000_000D;
    BotUpdt_in = 1'b1;
    tick(2);
    gpio.IO_INT_ACK = 1'b1;
    tick(1);
    chk("t4_col_sync", gpio.IO_BotUpdt_Sync, 1'b0);
    chk("t4_col_busy", busy, 1'b1);
    BotUpdt_in = 1'b0;
    tick(3);
    chk("t4_held_sync", gpio.IO_BotUpdt_Sync, 1'b0);
    ack(1'b0);
    chk("t4_re_sync", gpio.IO_BotUpdt_Sync, 1'b1);
    chk("t4_re_info", gpio.IO_BotInfo, 32'h0000_000D);
    chk("t4_ovr", ovr_count, 8'h00);
    ack(1'b1);
    ack(1'b0);
    chk("t4_idle", busy, 1'b0);

    // two updates while ACKED: second counts as overrun
    upd(32'h0000_00E0);
    ack(1'b1);
    upd(32'h0000_00E1);
    chk("acked_ovr0", ovr_count, 8'h00);
    upd(32'h0000_00E2);
    chk("acked_ovr1", ovr_count, 8'h01);
    chk("acked_sync", gpio.IO_BotUpdt_Sync, 1'b0);
    ack(1'b0);
    chk("acked_re_sync", gpio.IO_BotUpdt_Sync, 1'b1);
    chk("acked_re_info", gpio.IO_BotInfo, 32'h0000_00E2);
    ack(1'b1);
    ack(1'b0);
    chk("acked_idle", busy, 1'b0);

    // stuck ack before the update
    gpio.IO_INT_ACK = 1'b1;
    tick(2);
    upd(32'h0000_0055);
    chk("t5_sync", gpio.IO_BotUpdt_Sync, 1'b1);
    tick(5);
    chk("t5_stay", gpio.IO_BotUpdt_Sync, 1'b1);
    ack(1'b0);
    chk("t5_low", gpio.IO_BotUpdt_Sync, 1'b1);
    ack(1'b1);
    chk("t5_clr", gpio.IO_BotUpdt_Sync, 1'b0);
    chk("t5_busy", busy, 1'b1);
    ack(1'b0);
    chk("t5_idle", busy, 1'b0);

    // overrun counting and saturation
    do_reset();
    upd(32'h0000_000A);
    upd(32'h0000_000B);
    chk("t3_ovr1", ovr_count, 8'h01);
    chk("t3_info", gpio.IO_BotInfo, 32'h0000_000B);
    chk("t3_sync", gpio.IO_BotUpdt_Sync, 1'b1);
    for (int i = 0; i < 300; i++) upd(32'h1000_0000 + i);
    chk("t3_sat", ovr_count, 8'hFF);
    chk("t3_last", gpio.IO_BotInfo, 32'h1000_012B);

    // asynchronous reset while PENDING
    do_reset();
    for (int i = 0; i < 4; i++) upd(32'h2000_0000 + i);
    chk("t6_ovr3", ovr_count, 8'h03);
    chk("t6_pend", gpio.IO_BotUpdt_Sync, 1'b1);
    HRESETn = 1'b0;
    #1;
    chk("t6_sync", gpio.IO_BotUpdt_Sync, 1'b0);
    chk("t6_ovr", ovr_count, 8'h00);
    chk("t6_info", gpio.IO_BotInfo, 32'h0);
    chk("t6_busy", busy, 1'b0);
    tick(2);
    HRESETn = 1'b1;
    tick(5);
    single("t6b", 32'h9ABC_DEF0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
